// File: rtl/rv32_pkg.sv
// rv32_pkg
// Shared RV32I decode definitions: base opcodes, the bubble instruction,
// bit positions inside the decode control vector and an opcode-to-immediate
// format classifier used by the decode stage.
package rv32_pkg;

  // Base RV32I major opcodes (instr[6:0])
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // addi x0,x0,0 -- what a bubble looks like downstream
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // ctrl_out = {illegal, jump, branch, mem_write, mem_read, mem_to_reg, alu_src_imm, reg_write}
  localparam int CTRL_W           = 8;
  localparam int CTRL_REG_WRITE   = 0;
  localparam int CTRL_ALU_SRC_IMM = 1;
  localparam int CTRL_MEM_TO_REG  = 2;
  localparam int CTRL_MEM_READ    = 3;
  localparam int CTRL_MEM_WRITE   = 4;
  localparam int CTRL_BRANCH      = 5;
  localparam int CTRL_JUMP        = 6;
  localparam int CTRL_ILLEGAL     = 7;

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J,
    FMT_BAD
  } imm_fmt_e;

  // Which immediate layout an opcode uses; R-type and unknown opcodes carry none
  function automatic imm_fmt_e opcode_fmt(input logic [6:0] opcode);
    imm_fmt_e fmt;
    case (opcode)
      OP_R:                     fmt = FMT_R;
      OP_IMM, OP_LOAD, OP_JALR: fmt = FMT_I;
      OP_STORE:                 fmt = FMT_S;
      OP_BRANCH:                fmt = FMT_B;
      OP_LUI, OP_AUIPC:         fmt = FMT_U;
      OP_JAL:                   fmt = FMT_J;
      default:                  fmt = FMT_BAD;
    endcase
    return fmt;
  endfunction

endpackage

// File: rtl/reg_file.sv
// reg_file
// 32-entry architectural register file for the decode stage.
//   stage_clk, reset(active-low async clear)
//   we/waddr/wdata  : synchronous write port driven by writeback
//   raddr1/raddr2   : combinational read addresses
//   rdata1/rdata2   : read data; x0 always reads 0, and a same-cycle write
//                     to the addressed register is bypassed onto the read
module reg_file #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            stage_clk,
  input  logic            reset,
  input  logic            we,
  input  logic [4:0]      waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [4:0]      raddr1,
  input  logic [4:0]      raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2
);

  logic [XLEN-1:0] regs [NREGS];

  // Entry 0 is never written, so it stays at its cleared value of zero
  always_ff @(posedge stage_clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we && (waddr != 5'd0)) begin
      regs[waddr] <= wdata;
    end
  end

  // Bypass gives write-then-read semantics without waiting for the edge
  always_comb begin
    rdata1 = '0;
    if (raddr1 != 5'd0) begin
      if (we && (waddr == raddr1)) rdata1 = wdata;
      else                         rdata1 = regs[raddr1];
    end
  end

  always_comb begin
    rdata2 = '0;
    if (raddr2 != 5'd0) begin
      if (we && (waddr == raddr2)) rdata2 = wdata;
      else                         rdata2 = regs[raddr2];
    end
  end

endmodule

// File: rtl/decode_unit.sv
// decode_unit
// RV32I instruction decode stage feeding the ID/EX pipeline register.
//   stage_clk, reset(active-low async)
//   instr_in/pc_in   : instruction and its PC from fetch
//   stage_ena        : 1 = latch a new decode, 0 = hold
//   stage_x          : flush, inserts a bubble; wins over stage_ena
//   wb_we/wb_rd/wb_data : register-file write port from writeback
//   instr_out/pc_out/rs1_data/rs2_data/imm_out/rd_out/rs1_out/rs2_out/
//   ctrl_out/valid_out : registered decode results for execute
module decode_unit
  import rv32_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic              stage_clk,
  input  logic              reset,
  input  logic [XLEN-1:0]   instr_in,
  input  logic [XLEN-1:0]   pc_in,
  input  logic              stage_ena,
  input  logic              stage_x,
  input  logic              wb_we,
  input  logic [4:0]        wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  output logic [XLEN-1:0]   instr_out,
  output logic [XLEN-1:0]   pc_out,
  output logic [XLEN-1:0]   rs1_data,
  output logic [XLEN-1:0]   rs2_data,
  output logic [XLEN-1:0]   imm_out,
  output logic [4:0]        rd_out,
  output logic [4:0]        rs1_out,
  output logic [4:0]        rs2_out,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic              valid_out
);

  logic [6:0]        opcode;
  logic [4:0]        rd;
  logic [4:0]        rs1;
  logic [4:0]        rs2;
  imm_fmt_e          fmt;
  logic [31:0]       imm32;
  logic [XLEN-1:0]   imm_ext;
  logic [CTRL_W-1:0] ctrl;
  logic [XLEN-1:0]   rs1_rd_data;
  logic [XLEN-1:0]   rs2_rd_data;

  assign opcode = instr_in[6:0];
  assign rd     = instr_in[11:7];
  assign rs1    = instr_in[19:15];
  assign rs2    = instr_in[24:20];
  assign fmt    = opcode_fmt(opcode);

  reg_file #(
    .XLEN  (XLEN),
    .NREGS (NREGS)
  ) u_reg_file (
    .stage_clk (stage_clk),
    .reset     (reset),
    .we        (wb_we),
    .waddr     (wb_rd),
    .wdata     (wb_data),
    .raddr1    (rs1),
    .raddr2    (rs2),
    .rdata1    (rs1_rd_data),
    .rdata2    (rs2_rd_data)
  );

  // Reassemble the scattered immediate fields into a 32-bit signed value
  always_comb begin
    imm32 = '0;
    case (fmt)
      FMT_I:   imm32 = {{20{instr_in[31]}}, instr_in[31:20]};
      FMT_S:   imm32 = {{20{instr_in[31]}}, instr_in[31:25], instr_in[11:7]};
      FMT_B:   imm32 = {{19{instr_in[31]}}, instr_in[31], instr_in[7],
                        instr_in[30:25], instr_in[11:8], 1'b0};
      FMT_U:   imm32 = {instr_in[31:12], 12'h000};
      FMT_J:   imm32 = {{11{instr_in[31]}}, instr_in[31], instr_in[19:12],
                        instr_in[20], instr_in[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  assign imm_ext = {{(XLEN-31){imm32[31]}}, imm32[30:0]};

  // Control decode; an unknown opcode raises only the illegal bit and lets
  // execute take the exception. Writing x0 is pointless, so reg_write drops.
  always_comb begin
    ctrl = '0;
    case (opcode)
      OP_R: begin
        ctrl[CTRL_REG_WRITE] = 1'b1;
      end
      OP_IMM, OP_LUI, OP_AUIPC: begin
        ctrl[CTRL_REG_WRITE]   = 1'b1;
        ctrl[CTRL_ALU_SRC_IMM] = 1'b1;
      end
      OP_LOAD: begin
        ctrl[CTRL_REG_WRITE]   = 1'b1;
        ctrl[CTRL_ALU_SRC_IMM] = 1'b1;
        ctrl[CTRL_MEM_READ]    = 1'b1;
        ctrl[CTRL_MEM_TO_REG]  = 1'b1;
      end
      OP_STORE: begin
        ctrl[CTRL_ALU_SRC_IMM] = 1'b1;
        ctrl[CTRL_MEM_WRITE]   = 1'b1;
      end
      OP_BRANCH: begin
        ctrl[CTRL_BRANCH] = 1'b1;
      end
      OP_JAL, OP_JALR: begin
        ctrl[CTRL_REG_WRITE]   = 1'b1;
        ctrl[CTRL_ALU_SRC_IMM] = 1'b1;
        ctrl[CTRL_JUMP]        = 1'b1;
      end
      default: begin
        ctrl[CTRL_ILLEGAL] = 1'b1;
      end
    endcase
    if (rd == 5'd0) ctrl[CTRL_REG_WRITE] = 1'b0;
  end

  // ID/EX register: flush beats enable, otherwise everything holds
  always_ff @(posedge stage_clk or negedge reset) begin
    if (!reset) begin
      instr_out <= XLEN'(NOP_INSTR);
      pc_out    <= '0;
      rs1_data  <= '0;
      rs2_data  <= '0;
      imm_out   <= '0;
      rd_out    <= '0;
      rs1_out   <= '0;
      rs2_out   <= '0;
      ctrl_out  <= '0;
      valid_out <= 1'b0;
    end else if (stage_x) begin
      instr_out <= XLEN'(NOP_INSTR);
      pc_out    <= '0;
      rs1_data  <= '0;
      rs2_data  <= '0;
      imm_out   <= '0;
      rd_out    <= '0;
      rs1_out   <= '0;
      rs2_out   <= '0;
      ctrl_out  <= '0;
      valid_out <= 1'b0;
    end else if (stage_ena) begin
      instr_out <= instr_in;
      pc_out    <= pc_in;
      rs1_data  <= rs1_rd_data;
      rs2_data  <= rs2_rd_data;
      imm_out   <= imm_ext;
      rd_out    <= rd;
      rs1_out   <= rs1;
      rs2_out   <= rs2;
      ctrl_out  <= ctrl;
      valid_out <= 1'b1;
    end
  end

endmodule

// File: tb/tb_decode_unit.sv
// tb_decode_unit
// Directed and table-driven stimulus for decode_unit. A behavioural model
// tracks the architectural registers and the expected ID/EX contents; a
// compare process checks every output each cycle, and directed steps pin
// hand-computed values.
module tb_decode_unit;

  logic        stage_clk;
  logic        reset;
  logic [31:0] instr_in;
  logic [31:0] pc_in;
  logic        stage_ena;
  logic        stage_x;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [31:0] imm_out;
  logic [4:0]  rd_out;
  logic [4:0]  rs1_out;
  logic [4:0]  rs2_out;
  logic [7:0]  ctrl_out;
  logic        valid_out;

  int compared   = 0;
  int mismatched = 0;
  bit check_en   = 1'b0;

  decode_unit dut (
    .stage_clk (stage_clk),
    .reset     (reset),
    .instr_in  (instr_in),
    .pc_in     (pc_in),
    .stage_ena (stage_ena),
    .stage_x   (stage_x),
    .wb_we     (wb_we),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .instr_out (instr_out),
    .pc_out    (pc_out),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .imm_out   (imm_out),
    .rd_out    (rd_out),
    .rs1_out   (rs1_out),
    .rs2_out   (rs2_out),
    .ctrl_out  (ctrl_out),
    .valid_out (valid_out)
  );

  initial stage_clk = 1'b0;
  always #5 stage_clk = ~stage_clk;

  // Model state: architectural registers and the expected ID/EX contents
  logic [31:0] m_regs [32];
  logic [31:0] e_instr = 32'h13;
  logic [31:0] e_pc    = '0;
  logic [31:0] e_rs1d  = '0;
  logic [31:0] e_rs2d  = '0;
  logic [31:0] e_imm   = '0;
  logic [4:0]  e_rd    = '0;
  logic [4:0]  e_rs1   = '0;
  logic [4:0]  e_rs2   = '0;
  logic [7:0]  e_ctrl  = '0;
  logic        e_valid = 1'b0;

  // Immediate value by instruction format, built as signed numbers
  function automatic logic [31:0] spec_imm(input logic [31:0] ins);
    logic [6:0] op;
    op = ins[6:0];
    case (op)
      7'b0010011, 7'b0000011, 7'b1100111: return int'($signed(ins[31:20]));
      7'b0100011: return int'($signed({ins[31:25], ins[11:7]}));
      7'b1100011: return int'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
      7'b0110111, 7'b0010111: return {ins[31:12], 12'h000};
      7'b1101111: return int'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
      default: return 32'h0;
    endcase
  endfunction

  // Control vector from instruction class membership
  function automatic logic [7:0] spec_ctrl(input logic [31:0] ins);
    logic [6:0] op;
    logic legal, is_r, is_load, is_store, is_branch, is_jump, writes;
    op        = ins[6:0];
    legal     = op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                           7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
    is_r      = (op == 7'b0110011);
    is_load   = (op == 7'b0000011);
    is_store  = (op == 7'b0100011);
    is_branch = (op == 7'b1100011);
    is_jump   = op inside {7'b1101111, 7'b1100111};
    writes    = (op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0110111,
                            7'b0010111, 7'b1101111, 7'b1100111}) && (ins[11:7] != 5'd0);
    if (!legal) return 8'h80;
    return {1'b0, is_jump, is_branch, is_store, is_load, is_load, !(is_r || is_branch), writes};
  endfunction

  // Model update: writeback lands first, then the operands are read, which is
  // exactly the write-then-read behaviour the stage must show
  always @(posedge stage_clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
      e_instr = 32'h13; e_pc = '0; e_rs1d = '0; e_rs2d = '0; e_imm = '0;
      e_rd = '0; e_rs1 = '0; e_rs2 = '0; e_ctrl = '0; e_valid = 1'b0;
    end else begin
      if (wb_we && wb_rd != 5'd0) m_regs[wb_rd] = wb_data;
      if (stage_x) begin
        e_instr = 32'h13; e_pc = '0; e_rs1d = '0; e_rs2d = '0; e_imm = '0;
        e_rd = '0; e_rs1 = '0; e_rs2 = '0; e_ctrl = '0; e_valid = 1'b0;
      end else if (stage_ena) begin
        e_instr = instr_in;
        e_pc    = pc_in;
        e_rs1   = instr_in[19:15];
        e_rs2   = instr_in[24:20];
        e_rd    = instr_in[11:7];
        e_rs1d  = m_regs[instr_in[19:15]];
        e_rs2d  = m_regs[instr_in[24:20]];
        e_imm   = spec_imm(instr_in);
        e_ctrl  = spec_ctrl(instr_in);
        e_valid = 1'b1;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %08h, expected %08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of all outputs against the model
  always @(negedge stage_clk) begin
    if (check_en) begin
      checkOutput("instr_out", instr_out, e_instr);
      checkOutput("pc_out", pc_out, e_pc);
      checkOutput("rs1_data", rs1_data, e_rs1d);
      checkOutput("rs2_data", rs2_data, e_rs2d);
      checkOutput("imm_out", imm_out, e_imm);
      checkOutput("rd_out", 32'(rd_out), 32'(e_rd));
      checkOutput("rs1_out", 32'(rs1_out), 32'(e_rs1));
      checkOutput("rs2_out", 32'(rs2_out), 32'(e_rs2));
      checkOutput("ctrl_out", 32'(ctrl_out), 32'(e_ctrl));
      checkOutput("valid_out", 32'(valid_out), 32'(e_valid));
    end
  end

  // Drive one cycle of inputs and return just after the following falling edge
  task automatic applyStimulus(input logic [31:0] instr, input logic [31:0] pc,
                               input logic ena, input logic x, input logic we,
                               input logic [4:0] rd, input logic [31:0] data);
    instr_in  = instr;
    pc_in     = pc;
    stage_ena = ena;
    stage_x   = x;
    wb_we     = we;
    wb_rd     = rd;
    wb_data   = data;
    @(negedge stage_clk);
    #1;
  endtask

  logic [6:0]  ops [12];
  logic [31:0] rnd;
  logic [31:0] rnd_data;

  initial begin
    ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111,
            7'b1100111, 7'b0110111, 7'b0010111, 7'b1111111, 7'b0001111, 7'b1110011};
    reset     = 1'b0;
    instr_in  = 32'h13;
    pc_in     = '0;
    stage_ena = 1'b0;
    stage_x   = 1'b0;
    wb_we     = 1'b0;
    wb_rd     = '0;
    wb_data   = '0;

    applyStimulus(32'h13, 32'h0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
    applyStimulus(32'h13, 32'h0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
    check_en = 1'b1;
    checkOutput("reset instr_out", instr_out, 32'h0000_0013);
    checkOutput("reset valid_out", 32'(valid_out), 32'h0);
    checkOutput("reset ctrl_out", 32'(ctrl_out), 32'h0);
    reset = 1'b1;
    applyStimulus(32'h13, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);

    // wb x5, then addi x6,x5,5
    applyStimulus(32'h13, 32'h0, 1'b0, 1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF);
    applyStimulus(32'h0052_8313, 32'h100, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
    checkOutput("addi rs1_data", rs1_data, 32'hDEAD_BEEF);
    checkOutput("addi imm_out", imm_out, 32'h5);
    checkOutput("addi rd_out", 32'(rd_out), 32'd6);
    checkOutput("addi ctrl_out", 32'(ctrl_out), 32'h03);
    checkOutput("addi valid_out", 32'(valid_out), 32'h1);

    // add x2,x1,x2 with x1 written in the same cycle
    applyStimulus(32'h0020_8133, 32'h104, 1'b1, 1'b0, 1'b1, 5'd1, 32'h1234_5678);
    checkOutput("bypass rs1_data", rs1_data, 32'h1234_5678);
    checkOutput("add ctrl_out", 32'(ctrl_out), 32'h01);

    applyStimulus(32'hFE11_2E23, 32'h108, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
    checkOutput("sw imm_out", imm_out, 32'hFFFF_FFFC);
    checkOutput("sw ctrl_out", 32'(ctrl_out), 32'h12);

    applyStimulus(32'hFE00_0EE3, 32'h10C, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
    checkOutput("beq imm_out", imm_out, 32'hFFFF_FFFC);
    checkOutput("beq ctrl_out", 32'(ctrl_out), 32'h20);

    applyStimulus(32'h0000_10B7, 32'h110, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
    checkOutput("lui imm_out", imm_out, 32'h0000_1000);

    // Stall for three cycles with a different instruction on the input
    for (int i = 0; i < 3; i++)
      applyStimulus(32'h0000_007F, 32'h200, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    checkOutput("stall instr_out", instr_out, 32'h0000_10B7);
    checkOutput("stall pc_out", pc_out, 32'h110);

    // Flush wins over enable
    applyStimulus(32'h0052_8313, 32'h114, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0);
    checkOutput("flush valid_out", 32'(valid_out), 32'h0);
    checkOutput("flush instr_out", instr_out, 32'h0000_0013);
    checkOutput("flush rd_out", 32'(rd_out), 32'h0);

    // x0 write discarded, both on a prior cycle and same-cycle
    applyStimulus(32'h13, 32'h0, 1'b0, 1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF);
    applyStimulus(32'h0000_0393, 32'h118, 1'b1, 1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF);
    checkOutput("x0 rs1_data", rs1_data, 32'h0);

    applyStimulus(32'h0000_007F, 32'h11C, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
    checkOutput("illegal ctrl_out", 32'(ctrl_out), 32'h80);
    checkOutput("illegal valid_out", 32'(valid_out), 32'h1);

    // Mixed opcodes, writes, stalls and flushes
    for (int i = 0; i < 60; i++) begin
      rnd      = $urandom;
      rnd_data = $urandom;
      applyStimulus({rnd[31:7], ops[$urandom_range(0, 11)]}, 32'h400 + 32'(i * 4),
                    1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) == 0),
                    1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), rnd_data);
    end

    // Mid-run asynchronous reset
    applyStimulus(32'h13, 32'h0, 1'b0, 1'b0, 1'b1, 5'd5, 32'hCAFE_F00D);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("async reset instr_out", instr_out, 32'h0000_0013);
    checkOutput("async reset valid_out", 32'(valid_out), 32'h0);
    checkOutput("async reset ctrl_out", 32'(ctrl_out), 32'h0);
    applyStimulus(32'h0052_8313, 32'h120, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
    applyStimulus(32'h0052_8313, 32'h120, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
    reset = 1'b1;
    applyStimulus(32'h0052_8313, 32'h124, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
    checkOutput("post-reset x5 rs1_data", rs1_data, 32'h0);
    checkOutput("post-reset pc_out", pc_out, 32'h124);
    applyStimulus(32'h13, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
